// File: rtl/avg_seq_pkg.sv
// Shared state encoding and timing constants for the averaging RAM sequencer.
package avg_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SETTLE,
        WRITE,
        CLEAR,
        DONE
    } seq_state_t;

    localparam int SETTLE_CYCLES = 1;

endpackage

// File: rtl/avg_seq_addr_gen.sv
// RAM write-address counter: increments per average, wraps at DEPTH, flags the last word.
module avg_seq_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inc,
    input  logic              clr,
    output logic [ADDR_W-1:0] addr,
    output logic              at_last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    assign at_last = (addr == LAST_ADDR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (inc) begin
            addr <= at_last ? '0 : addr + 1'b1;
        end
    end

endmodule

// File: rtl/avg_ram_sequencer.sv
// Counted, framed FIFO -> averager -> RAM sequencer on the 2 MHz side.
// Define AVG_SEQ_WRAP_EN to wrap the RAM address and keep running instead of stopping in DONE.
module avg_ram_sequencer
    import avg_seq_pkg::*;
#(
    parameter int SAMPLES   = 4,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int RAM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    output logic              avg_add,
    output logic              avg_clear,
    input  logic [DATA_W-1:0] avg_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              done
);

    localparam int               CNT_W    = $clog2(SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLES);

    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] rd_cnt;
    logic             clear_nxt;
    logic             addr_inc;
    logic             addr_clr;
    logic             at_last;

    avg_seq_addr_gen #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAM_DEPTH)
    ) u_addr_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (addr_inc),
        .clr     (addr_clr),
        .addr    (ram_addr),
        .at_last (at_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clear_nxt = 1'b0;
        addr_inc  = 1'b0;
        addr_clr  = 1'b0;
        fifo_rd   = 1'b0;
        ram_we    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = FILL;
                    clear_nxt = 1'b1;
                end
            end
            FILL: begin
                // Hold reads off while the entry clear is on the averager so it never overlaps an add.
                fifo_rd = !fifo_empty && (rd_cnt < CNT_FULL) && !avg_clear;
                if (avg_add && (rd_cnt == CNT_FULL)) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                state_nxt = WRITE;
            end
            WRITE: begin
                ram_we    = 1'b1;
                clear_nxt = 1'b1;
                state_nxt = CLEAR;
            end
            CLEAR: begin
`ifdef AVG_SEQ_WRAP_EN
                done = at_last;
                if (at_last && !enable) begin
                    addr_clr  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    addr_inc  = 1'b1;
                    state_nxt = FILL;
                end
`else
                if (at_last) begin
                    state_nxt = DONE;
                end else begin
                    addr_inc  = 1'b1;
                    state_nxt = FILL;
                end
`endif
            end
            DONE: begin
                done = 1'b1;
                if (!enable) begin
                    addr_clr  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered strobes, sample count and captured average
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt    <= '0;
            avg_add   <= 1'b0;
            avg_clear <= 1'b0;
            ram_wdata <= '0;
        end else begin
            avg_add   <= fifo_rd;
            avg_clear <= clear_nxt;
            if (state == IDLE || state == CLEAR) begin
                rd_cnt <= '0;
            end else if (fifo_rd) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (state == SETTLE) begin
                ram_wdata <= avg_data;
            end
        end
    end

endmodule

// File: tb/tb_avg_ram_sequencer.sv
// Bench for avg_ram_sequencer: FIFO and averager models, scenario tasks, write/pop logging.
module tb_avg_ram_sequencer;
    import avg_seq_pkg::*;

    localparam int SAMPLES = 4;
    localparam int DEPTH   = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd, avg_add, avg_clear, ram_we, done;
    logic [7:0] avg_data, ram_addr, ram_wdata;

    typedef struct {
        int cyc;
        int addr;
        int data;
        int pops;
    } wr_t;

    wr_t writes[$];
    int  popped[$];
    int  pop_cyc[$];
    int  done_cyc[$];
    int  cyc = 0;
    int  acc = 0;
    int  fifo_dout = 0;
    int  smp;
    bit  avg_force = 1'b0;
    int  n_tests = 0;
    int  n_fail = 0;

    always #5 clk = ~clk;

    assign avg_data = avg_force ? 8'h5A : 8'(acc / SAMPLES);

    avg_ram_sequencer #(
        .SAMPLES   (SAMPLES),
        .DATA_W    (8),
        .ADDR_W    (8),
        .RAM_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .avg_add    (avg_add),
        .avg_clear  (avg_clear),
        .avg_data   (avg_data),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .done       (done)
    );

    // FIFO source, averager and event logger
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd === 1'b1) begin
            smp = int'($urandom_range(0, 255));
            popped.push_back(smp);
            pop_cyc.push_back(cyc);
            fifo_dout <= smp;
        end
        if (ram_we === 1'b1) writes.push_back('{cyc, int'(ram_addr), int'(ram_wdata), popped.size()});
        if (done === 1'b1) done_cyc.push_back(cyc);
        if (avg_clear === 1'b1) acc <= 0;
        else if (avg_add === 1'b1) acc <= acc + fifo_dout;
    end

    function automatic int grp_mean(int k);
        int s = 0;
        for (int j = 0; j < SAMPLES; j++)
            if (k * SAMPLES + j < popped.size()) s += popped[k * SAMPLES + j];
        return s / SAMPLES;
    endfunction

    task automatic clear_log();
        writes.delete();
        popped.delete();
        pop_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic apply_reset();
        reset_n    = 1'b0;
        enable     = 1'b0;
        fifo_empty = 1'b1;
        avg_force  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_log();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; fifo_empty = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL rst_fifo_rd got %b want 0", fifo_rd); end
        n_tests++; if (avg_add !== 1'b0) begin n_fail++; $display("FAIL rst_avg_add got %b want 0", avg_add); end
        n_tests++; if (avg_clear !== 1'b0) begin n_fail++; $display("FAIL rst_avg_clear got %b want 0", avg_clear); end
        n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we got %b want 0", ram_we); end
        n_tests++; if (ram_addr !== 8'h00) begin n_fail++; $display("FAIL rst_ram_addr got %h want 00", ram_addr); end
        n_tests++; if (ram_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_ram_wdata got %h want 00", ram_wdata); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        clear_log();
        @(negedge clk);
        n_tests++; if (avg_clear !== 1'b0) begin n_fail++; $display("FAIL rel_idle_clear got %b want 0", avg_clear); end
        @(negedge clk);
        n_tests++; if (avg_clear !== 1'b1) begin n_fail++; $display("FAIL rel_clear_pulse got %b want 1", avg_clear); end
        n_tests++; if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL rel_rd_during_clear got %b want 0", fifo_rd); end
        for (int i = 0; i < SAMPLES; i++) begin
            @(negedge clk);
            n_tests++; if (fifo_rd !== 1'b1 || avg_clear !== 1'b0)
                begin n_fail++; $display("FAIL rel_read%0d got rd=%b clr=%b want rd=1 clr=0", i, fifo_rd, avg_clear); end
        end
        @(negedge clk);
        n_tests++; if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL rel_fifth_read got %b want 0", fifo_rd); end
    endtask

    task automatic test_latency();
        apply_reset();
        avg_force = 1'b1; fifo_empty = 1'b0; enable = 1'b1;
        for (int i = 0; i < 40 && writes.size() == 0; i++) @(negedge clk);
        n_tests++;
        if (writes.size() == 0 || pop_cyc.size() < SAMPLES) begin
            n_fail++; $display("FAIL lat_timeout got %0d writes want 1", writes.size());
        end else begin
            if (writes[0].cyc - pop_cyc[SAMPLES-1] !== 2 + SETTLE_CYCLES)
                begin n_fail++; $display("FAIL lat_cycles got %0d want %0d", writes[0].cyc - pop_cyc[SAMPLES-1], 2 + SETTLE_CYCLES); end
            n_tests++; if (writes[0].addr !== 0) begin n_fail++; $display("FAIL lat_addr got %0d want 0", writes[0].addr); end
            n_tests++; if (writes[0].data !== 'h5A) begin n_fail++; $display("FAIL lat_wdata got %0h want 5a", writes[0].data); end
            n_tests++; if (writes[0].pops !== SAMPLES) begin n_fail++; $display("FAIL lat_pops got %0d want %0d", writes[0].pops, SAMPLES); end
        end
        repeat (3) @(negedge clk);
        n_tests++; if (writes.size() !== 1) begin n_fail++; $display("FAIL lat_single_we got %0d writes want 1", writes.size()); end
        avg_force = 1'b0;
    endtask

    task automatic test_empty_toggle();
        logic prev_rd;
        apply_reset();
        enable  = 1'b1;
        prev_rd = 1'b0;
        for (int i = 0; i < 200 && writes.size() < 2; i++) begin
            @(posedge clk); #1;
            fifo_empty = (i % 2 == 1);
            @(negedge clk);
            n_tests++; if (fifo_rd === 1'b1 && fifo_empty) begin n_fail++; $display("FAIL tog_read_while_empty got rd=1 want 0 (cycle %0d)", i); end
            n_tests++; if (avg_add !== prev_rd) begin n_fail++; $display("FAIL tog_add_delay got %b want %b (cycle %0d)", avg_add, prev_rd, i); end
            prev_rd = fifo_rd;
        end
        n_tests++; if (writes.size() !== 2) begin n_fail++; $display("FAIL tog_writes got %0d want 2", writes.size()); end
        for (int k = 0; k < 2 && k < writes.size(); k++) begin
            n_tests++; if (writes[k].pops !== SAMPLES * (k + 1)) begin n_fail++; $display("FAIL tog_pops%0d got %0d want %0d", k, writes[k].pops, SAMPLES * (k + 1)); end
            n_tests++; if (writes[k].addr !== k) begin n_fail++; $display("FAIL tog_addr%0d got %0d want %0d", k, writes[k].addr, k); end
            n_tests++; if (writes[k].data !== grp_mean(k)) begin n_fail++; $display("FAIL tog_data%0d got %0d want %0d", k, writes[k].data, grp_mean(k)); end
        end
    endtask

`ifdef AVG_SEQ_WRAP_EN
    task automatic test_wrap();
        apply_reset();
        enable = 1'b1;
        for (int i = 0; i < 1500 && writes.size() < 6; i++) begin
            @(posedge clk); #1;
            fifo_empty = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        n_tests++; if (writes.size() !== 6) begin n_fail++; $display("FAIL wrap_writes got %0d want 6", writes.size()); end
        for (int k = 0; k < writes.size(); k++) begin
            n_tests++; if (writes[k].addr !== k % DEPTH) begin n_fail++; $display("FAIL wrap_addr%0d got %0d want %0d", k, writes[k].addr, k % DEPTH); end
            n_tests++; if (writes[k].data !== grp_mean(k)) begin n_fail++; $display("FAIL wrap_data%0d got %0d want %0d", k, writes[k].data, grp_mean(k)); end
        end
        n_tests++; if (done_cyc.size() !== 1) begin n_fail++; $display("FAIL wrap_done_count got %0d want 1", done_cyc.size()); end
        if (done_cyc.size() >= 1 && writes.size() >= 4) begin
            n_tests++; if (done_cyc[0] !== writes[3].cyc + 1) begin n_fail++; $display("FAIL wrap_done_cycle got %0d want %0d", done_cyc[0], writes[3].cyc + 1); end
        end
        @(posedge clk); #1;
        enable = 1'b0;
        for (int i = 0; i < 600 && done_cyc.size() < 2; i++) begin
            @(posedge clk); #1;
            fifo_empty = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        n_tests++; if (done_cyc.size() !== 2) begin n_fail++; $display("FAIL wrap_stop_timeout got %0d done pulses want 2", done_cyc.size()); end
        fifo_empty = 1'b0;
        repeat (8) @(negedge clk);
        n_tests++; if (fifo_rd !== 1'b0 || ram_addr !== 8'h00)
            begin n_fail++; $display("FAIL wrap_idle got rd=%b addr=%0d want rd=0 addr=0", fifo_rd, ram_addr); end
        n_tests++; if (writes.size() !== 8) begin n_fail++; $display("FAIL wrap_stop_writes got %0d want 8", writes.size()); end
    endtask
`else
    task automatic test_full_run();
        apply_reset();
        enable = 1'b1;
        for (int i = 0; i < 800 && done !== 1'b1; i++) begin
            @(posedge clk); #1;
            fifo_empty = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            n_tests++; if (fifo_rd === 1'b1 && fifo_empty) begin n_fail++; $display("FAIL run_read_while_empty got rd=1 want 0 (cycle %0d)", i); end
        end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL run_done_timeout got %b want 1", done); end
        n_tests++; if (writes.size() !== DEPTH) begin n_fail++; $display("FAIL run_writes got %0d want %0d", writes.size(), DEPTH); end
        for (int k = 0; k < DEPTH && k < writes.size(); k++) begin
            n_tests++; if (writes[k].addr !== k) begin n_fail++; $display("FAIL run_addr%0d got %0d want %0d", k, writes[k].addr, k); end
            n_tests++; if (writes[k].data !== grp_mean(k)) begin n_fail++; $display("FAIL run_data%0d got %0d want %0d", k, writes[k].data, grp_mean(k)); end
            n_tests++; if (writes[k].pops !== SAMPLES * (k + 1)) begin n_fail++; $display("FAIL run_pops%0d got %0d want %0d", k, writes[k].pops, SAMPLES * (k + 1)); end
        end
        @(posedge clk); #1;
        fifo_empty = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++; if (done !== 1'b1 || ram_addr !== 8'(DEPTH - 1) || fifo_rd !== 1'b0)
                begin n_fail++; $display("FAIL run_hold got done=%b addr=%0d rd=%b want done=1 addr=%0d rd=0", done, ram_addr, fifo_rd, DEPTH - 1); end
        end
        @(posedge clk); #1;
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL run_release_done got %b want 0", done); end
        n_tests++; if (ram_addr !== 8'h00) begin n_fail++; $display("FAIL run_release_addr got %0d want 0", ram_addr); end
        repeat (3) @(negedge clk);
        n_tests++; if (fifo_rd !== 1'b0 || writes.size() !== DEPTH)
            begin n_fail++; $display("FAIL run_idle got rd=%b writes=%0d want rd=0 writes=%0d", fifo_rd, writes.size(), DEPTH); end
    endtask
`endif

    task automatic test_reset_mid_fill();
        apply_reset();
        enable = 1'b1; fifo_empty = 1'b0;
        for (int i = 0; i < 20 && popped.size() < 2; i++) begin
            @(posedge clk); #1;
        end
        n_tests++; if (fifo_rd !== 1'b1 || popped.size() !== 2)
            begin n_fail++; $display("FAIL mid_pre got rd=%b pops=%0d want rd=1 pops=2", fifo_rd, popped.size()); end
        reset_n = 1'b0;
        #1;
        n_tests++; if (fifo_rd !== 1'b0 || avg_add !== 1'b0 || avg_clear !== 1'b0)
            begin n_fail++; $display("FAIL mid_strobes got rd=%b add=%b clr=%b want 0 0 0", fifo_rd, avg_add, avg_clear); end
        n_tests++; if (ram_we !== 1'b0 || ram_addr !== 8'h00 || done !== 1'b0)
            begin n_fail++; $display("FAIL mid_ram got we=%b addr=%0d done=%b want 0 0 0", ram_we, ram_addr, done); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        clear_log();
        for (int i = 0; i < 40 && writes.size() == 0; i++) @(negedge clk);
        n_tests++;
        if (writes.size() == 0) begin
            n_fail++; $display("FAIL mid_restart_timeout got 0 writes want 1");
        end else begin
            if (writes[0].pops !== SAMPLES) begin n_fail++; $display("FAIL mid_restart_pops got %0d want %0d", writes[0].pops, SAMPLES); end
            n_tests++; if (writes[0].addr !== 0) begin n_fail++; $display("FAIL mid_restart_addr got %0d want 0", writes[0].addr); end
            n_tests++; if (writes[0].data !== grp_mean(0)) begin n_fail++; $display("FAIL mid_restart_data got %0d want %0d", writes[0].data, grp_mean(0)); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_empty_toggle();
`ifdef AVG_SEQ_WRAP_EN
        test_wrap();
`else
        test_full_run();
`endif
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
